// File: rtl/emif_write_pkg.sv
// Shared EMIF definitions: FSM encodings, bus defaults and the status-word address map.
// Used by the FPGA->MCU return path and by the MCU->FPGA capture path.
package emif_write_pkg;

  localparam int          EMIF_ADDR_W   = 13;
  localparam logic [15:0] EMIF_BAD_DATA = 16'hDEAD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  // Status-word address map shared with the capture path
  localparam int ADDR_ENC_POS  = 0;
  localparam int ADDR_ENC_VEL  = 1;
  localparam int ADDR_ENC_STAT = 2;
  localparam int ADDR_ENC_MODE = 3;
  localparam int ADDR_FAULT    = 4;

  function automatic logic addr_in_range(input logic [31:0] a, input int n);
    return a < 32'(n);
  endfunction

endpackage

// File: rtl/emif_write_sync2.sv
// Generic two-flop synchroniser, parameterised by width; shared with the capture path.
module emif_write_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/emif_write.sv
// EMIF read-return path: drives a selected status word onto the EMIF bus after a read strobe.
// Optional EMIF_WORD_LATCH_EN adds a shadow giving 32-bit coherent reads of word pairs (2n, 2n+1).
module emif_write
  import emif_write_pkg::*;
#(
  parameter int          ADDR_W    = EMIF_ADDR_W,
  parameter int          NUM_REGS  = 8,
  parameter int          DRIVE_DLY = 5,
  parameter logic [15:0] BAD_DATA  = EMIF_BAD_DATA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      emif_addr,
  input  logic [16*NUM_REGS-1:0] status_bus,
  output logic [15:0]            data_out,
  output logic                   data_oe,
  output logic                   rd_done,
  output logic                   addr_err
);

  localparam int CNT_W = $clog2(DRIVE_DLY + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                          rd_s;
  logic [ADDR_W-1:0]             addr_s;
  logic [ADDR_W-1:0]             addr_l;
  logic [1:0]                    state;
  logic [CNT_W-1:0]              cnt;
  logic [NUM_REGS-1:0][15:0]     words;
  logic [IDX_W-1:0]              idx;
  logic                          in_range;
  logic                          load;
  logic [15:0]                   sel_word;

  emif_write_sync2 #(.W(1)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .d(rd_en), .q(rd_s)
  );

  emif_write_sync2 #(.W(ADDR_W)) u_sync_addr (
    .clk(clk), .rst_n(rst_n), .d(emif_addr), .q(addr_s)
  );

  assign words    = status_bus;
  assign idx      = addr_l[IDX_W-1:0];
  // Full-width unsigned compare so high address bits never alias onto a valid word
  assign in_range = addr_in_range(32'(addr_l), NUM_REGS);
  assign load     = (state == S_WAIT) && rd_s && (cnt == CNT_W'(DRIVE_DLY - 1));

`ifdef EMIF_WORD_LATCH_EN
  logic [15:0]      shadow;
  logic [IDX_W-1:0] idx_odd;
  logic             pair_ok;

  assign idx_odd = idx | IDX_W'(1);
  assign pair_ok = addr_in_range(32'(idx_odd), NUM_REGS);

  // Odd words always come from the snapshot taken by the preceding even read
  always_comb begin
    sel_word = words[idx];
    if (addr_l[0]) sel_word = shadow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (load && in_range && !addr_l[0])
      shadow <= pair_ok ? words[idx_odd] : '0;
  end
`else
  assign sel_word = words[idx];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_l   <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      rd_done  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_s) begin
            state  <= S_WAIT;
            cnt    <= CNT_W'(1);
            addr_l <= addr_s;
          end
        end
        S_WAIT: begin
          if (!rd_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (load) begin
            state    <= S_DRIVE;
            cnt      <= '0;
            data_oe  <= 1'b1;
            data_out <= in_range ? sel_word : BAD_DATA;
            if (!in_range) addr_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRIVE: begin
          // Word stays frozen until the strobe drops
          if (!rd_s) begin
            state    <= S_IDLE;
            data_oe  <= 1'b0;
            data_out <= '0;
            rd_done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emif_write.sv
// Directed bench for emif_write: latency, abort, range errors, freeze, async reset, word latch.
module tb_emif_write;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [12:0]   emif_addr;
  logic [127:0]  status_bus;
  logic [15:0]   data_out;
  logic          data_oe;
  logic          rd_done;
  logic          addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat, fall, pulses;
  logic [15:0] d;
  bit          stable;

  emif_write dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .emif_addr(emif_addr),
    .status_bus(status_bus), .data_out(data_out), .data_oe(data_oe),
    .rd_done(rd_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [15:0] v);
    status_bus[k*16 +: 16] = v;
  endtask

  // One read transaction: strobe high for 'hold' edges, then low for 10 edges.
  task automatic rd(input logic [12:0] a, input int hold, input bit mutate,
                    output int lat_o, output logic [15:0] d_o, output bit stable_o,
                    output int fall_o, output int pulses_o);
    lat_o = -1; d_o = '0; stable_o = 1'b1; fall_o = -1; pulses_o = 0;
    emif_addr = a;
    rd_en     = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (data_oe && lat_o < 0) begin
        lat_o = i;
        d_o   = data_out;
      end else if (lat_o >= 0 && (!data_oe || data_out !== d_o)) begin
        stable_o = 1'b0;
      end
      if (mutate && lat_o >= 0 && i == lat_o + 2) begin
        set_word(2, 16'hBEEF);
        emif_addr = 13'd5;
      end
    end
    rd_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (!data_oe && fall_o < 0) fall_o = i;
      if (rd_done) pulses_o++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; emif_addr = '0; status_bus = '0;
    for (int k = 0; k < 8; k++) set_word(k, 16'h1000 + 16'(k));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_data_oe",  32'(data_oe),  0);
    chk("rst_rd_done",  32'(rd_done),  0);
    chk("rst_addr_err", 32'(addr_err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // basic read
    set_word(2, 16'h1234);
    rd(13'd2, 20, 1'b0, lat, d, stable, fall, pulses);
    chk("basic_latency", 32'(lat), 7);
    chk("basic_data", 32'(d), 32'h1234);
    chk("basic_stable", 32'(stable), 1);
    chk("basic_fall_window", 32'(fall >= 2 && fall <= 3), 1);
    chk("basic_done_pulses", 32'(pulses), 1);
    chk("basic_data_after", 32'(data_out), 0);
    chk("basic_no_err", 32'(addr_err), 0);

    // aborted read
    rd(13'd2, 3, 1'b0, lat, d, stable, fall, pulses);
    chk("abort_no_oe", 32'(lat), 32'hFFFF_FFFF);
    chk("abort_no_done", 32'(pulses), 0);
    chk("abort_data", 32'(data_out), 0);

    // highest valid address
    rd(13'd7, 12, 1'b0, lat, d, stable, fall, pulses);
    chk("addr7_data", 32'(d), 32'h1007);
    chk("addr7_no_err", 32'(addr_err), 0);

    // first out-of-range address
    rd(13'd8, 12, 1'b0, lat, d, stable, fall, pulses);
    chk("addr8_data", 32'(d), 32'hDEAD);
    chk("addr8_err", 32'(addr_err), 1);

    // out-of-range address 9, then sticky through a valid read
    rd(13'd9, 12, 1'b0, lat, d, stable, fall, pulses);
    chk("addr9_data", 32'(d), 32'hDEAD);
    chk("addr9_done", 32'(pulses), 1);
    set_word(3, 16'h3333);
    rd(13'd3, 12, 1'b0, lat, d, stable, fall, pulses);
    chk("addr3_data", 32'(d), 32'h3333);
    chk("err_sticky", 32'(addr_err), 1);

    // high bits must not alias onto word 2
    rd(13'h1002, 12, 1'b0, lat, d, stable, fall, pulses);
    chk("alias_data", 32'(d), 32'hDEAD);

    // word and address change mid-drive are ignored
    set_word(2, 16'h1234);
    rd(13'd2, 20, 1'b1, lat, d, stable, fall, pulses);
    chk("mid_data", 32'(d), 32'h1234);
    chk("mid_stable", 32'(stable), 1);
    chk("mid_done", 32'(pulses), 1);

    // async reset while driving
    set_word(2, 16'h2222);
    emif_addr = 13'd2;
    rd_en = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_oe", 32'(data_oe), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", 32'(data_oe), 0);
    chk("async_rst_data", 32'(data_out), 0);
    chk("async_rst_err", 32'(addr_err), 0);
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // odd read before any even read
    set_word(1, 16'h4444);
    rd(13'd1, 12, 1'b0, lat, d, stable, fall, pulses);
`ifdef EMIF_WORD_LATCH_EN
    chk("odd_first", 32'(d), 32'h0000);
`else
    chk("odd_first", 32'(d), 32'h4444);
`endif

    // post-reset read behaves normally
    rd(13'd2, 14, 1'b0, lat, d, stable, fall, pulses);
    chk("post_rst_latency", 32'(lat), 7);
    chk("post_rst_data", 32'(d), 32'h2222);

    // word latch pair coherency
    set_word(0, 16'hAAAA);
    set_word(1, 16'h5555);
    rd(13'd0, 12, 1'b0, lat, d, stable, fall, pulses);
    chk("latch_even", 32'(d), 32'hAAAA);
    set_word(1, 16'h7777);
    rd(13'd1, 12, 1'b0, lat, d, stable, fall, pulses);
`ifdef EMIF_WORD_LATCH_EN
    chk("latch_odd", 32'(d), 32'h5555);
`else
    chk("latch_odd", 32'(d), 32'h7777);
`endif

    // aborted even read leaves the shadow alone
    set_word(1, 16'h9999);
    rd(13'd0, 3, 1'b0, lat, d, stable, fall, pulses);
    rd(13'd1, 12, 1'b0, lat, d, stable, fall, pulses);
`ifdef EMIF_WORD_LATCH_EN
    chk("latch_abort", 32'(d), 32'h5555);
`else
    chk("latch_abort", 32'(d), 32'h9999);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
